// File: rtl/neuron_layer_ctrl.sv
// Sequencer for one layer of free-running neuron units: input vector register,
// valid delay line and credit-guarded result FIFO. Optional NEURON_LAYER_CTRL_STATS_EN adds counters.
module neuron_layer_ctrl #(
  parameter int N_NEURONS  = 10,
  parameter int PIPE_LAT   = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [64*DATA_W-1:0]   in_data,
  input  logic                   flush,
  output logic [64*DATA_W-1:0]   neuron_in,
  input  logic [N_NEURONS*8-1:0] neuron_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_NEURONS*8-1:0] out_data,
  output logic                   busy,
  output logic [15:0]            stat_accepted,
  output logic [15:0]            stat_stall
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(PIPE_LAT + 1);
  localparam int OW = N_NEURONS * 8;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic                live;
  logic [PIPE_LAT:1]   vld_pipe;
  logic [CW-1:0]       inflight, fifo_count;
  logic [CW:0]         credit_used;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [OW-1:0]       mem [FIFO_DEPTH];
  logic [LW-1:0]       flush_cnt;
  logic                accept, capture, pop;

  // Credits cover both in-flight samples and buffered results, so a capture always finds space.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign in_ready    = live && (state != FLUSH) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready && !flush;
  assign capture     = vld_pipe[PIPE_LAT];
  assign out_valid   = (fifo_count != '0);
  assign pop         = out_valid && out_ready;
  assign out_data    = mem[rd_ptr];
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (inflight == '0 && fifo_count == '0 && !accept) state_nxt = IDLE;
      FLUSH:   if (flush_cnt == LW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      live       <= 1'b0;
      vld_pipe   <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      flush_cnt  <= '0;
      neuron_in  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (accept) neuron_in <= in_data;
      if (flush) begin
        // Stale neuron pipeline contents drain while the counter runs down.
        vld_pipe   <= '0;
        inflight   <= '0;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        flush_cnt  <= LW'(PIPE_LAT);
      end else begin
        vld_pipe   <= {vld_pipe[PIPE_LAT-1:1], accept};
        inflight   <= inflight + CW'(accept) - CW'(capture);
        fifo_count <= fifo_count + CW'(capture) - CW'(pop);
        if (capture) begin
          mem[wr_ptr] <= neuron_out;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (flush_cnt != '0) flush_cnt <= flush_cnt - LW'(1);
      end
    end
  end

`ifdef NEURON_LAYER_CTRL_STATS_EN
  logic [15:0] acc_cnt, stall_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
      if (in_valid && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
  assign stat_accepted = acc_cnt;
  assign stat_stall    = stall_cnt;
`else
  assign stat_accepted = '0;
  assign stat_stall    = '0;
`endif

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Randomized bench for neuron_layer_ctrl: a stub neuron pipeline plus a scoreboard
// of accepted vectors with their availability times.
module tb_neuron_layer_ctrl;
  localparam int N_NEURONS  = 10;
  localparam int PIPE_LAT   = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int DATA_W     = 32;
  localparam int VW = 64 * DATA_W;
  localparam int OW = N_NEURONS * 8;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [VW-1:0] in_data, neuron_in;
  logic [OW-1:0] neuron_out, out_data;
  logic [15:0]   stat_accepted, stat_stall;

  neuron_layer_ctrl #(.N_NEURONS(N_NEURONS), .PIPE_LAT(PIPE_LAT),
                      .FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .neuron_in(neuron_in),
    .neuron_out(neuron_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .stat_accepted(stat_accepted),
    .stat_stall(stat_stall));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Neuron j activation: byte j plus mirrored byte plus a bias; all-ones gives 8'hA5.
  function automatic logic [OW-1:0] act(input logic [VW-1:0] v);
    logic [OW-1:0] r;
    for (int j = 0; j < N_NEURONS; j++)
      r[j*8 +: 8] = v[j*DATA_W +: 8] + v[(63-j)*DATA_W +: 8] + 8'hA3;
    return r;
  endfunction

  // Stub neuron pipeline: neuron_in register plus PIPE_LAT-1 internal stages.
  logic [OW-1:0] st [PIPE_LAT-1];
  always @(posedge clk) begin
    st[0] <= act(neuron_in);
    for (int i = 1; i < PIPE_LAT - 1; i++) st[i] <= st[i-1];
  end
  assign neuron_out = st[PIPE_LAT-2];

  // A capture into a full FIFO without a pop must never happen.
  always @(negedge clk)
    if (rst_n && dut.vld_pipe[PIPE_LAT] && int'(dut.fifo_count) == FIFO_DEPTH &&
        !(out_valid && out_ready))
      chk("fifo_overflow", 128'(1), 128'(0));

  typedef struct { logic [OW-1:0] res; int t; } item_t;
  item_t         q[$];
  int            cyc = 0;
  int            m_flush_left = 0;
  bit            m_live = 0, m_run = 0;
  int            m_acc = 0, m_stall = 0;
  logic [VW-1:0] m_ni = '0;
  logic [VW-1:0] vec;
  int            n_acc_obs;

  task automatic rand_vec();
    for (int i = 0; i < 64; i++) vec[i*DATA_W +: DATA_W] = $urandom;
  endtask

  task automatic step(input bit v, input bit fl, input bit ordy);
    bit exp_rdy, exp_ov, acc, pp;
    in_valid = v; flush = fl; out_ready = ordy; in_data = vec;
    exp_rdy = m_live && m_flush_left == 0 && q.size() < FIFO_DEPTH;
    exp_ov  = q.size() > 0 && q[0].t <= cyc;
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("out_valid", 128'(out_valid), 128'(exp_ov));
    if (exp_ov) chk("out_data", 128'(out_data), 128'(q[0].res));
    chk("busy", 128'(busy), 128'(m_run || m_flush_left != 0));
    chk("neuron_in", 128'(neuron_in == m_ni), 128'(1));
`ifdef NEURON_LAYER_CTRL_STATS_EN
    chk("stat_accepted", 128'(stat_accepted), 128'(m_acc));
    chk("stat_stall", 128'(stat_stall), 128'(m_stall));
`else
    chk("stat_accepted", 128'(stat_accepted), 128'(0));
    chk("stat_stall", 128'(stat_stall), 128'(0));
`endif
    acc = v && exp_rdy && !fl;
    pp  = exp_ov && ordy;
    if (v && in_ready && !fl) n_acc_obs++;
    @(posedge clk); #1;
    cyc++;
    if (!rst_n) begin
      q.delete(); m_flush_left = 0; m_live = 0; m_run = 0;
      m_acc = 0; m_stall = 0; m_ni = '0;
    end else begin
      if (v && !exp_rdy && m_stall < 16'hFFFF) m_stall++;
      m_live = 1;
      if (fl) begin
        q.delete(); m_flush_left = PIPE_LAT; m_run = 0;
      end else begin
        if (m_flush_left > 0) m_flush_left--;
        m_run = acc || (m_run && q.size() > 0);
        if (pp) void'(q.pop_front());
        if (acc) begin
          q.push_back('{res: act(vec), t: cyc + PIPE_LAT});
          m_ni = vec;
          if (m_acc < 16'hFFFF) m_acc++;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0; in_data = '0;
    rand_vec();
    #1;
    // Reset held with in_valid asserted.
    repeat (3) step(1, 0, 0);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_neuron_in", 128'(neuron_in == '0), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    rst_n = 1'b1;
    step(0, 0, 0);
    chk("post_rst_ready", 128'(in_ready), 128'(1));

    // Single all-ones vector.
    for (int i = 0; i < 64; i++) vec[i*DATA_W +: DATA_W] = 32'd1;
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    chk("single_early", 128'(out_valid), 128'(0));
    step(0, 0, 0);
    chk("single_valid", 128'(out_valid), 128'(1));
    chk("single_data", 128'(out_data), 128'({N_NEURONS{8'hA5}}));
    step(0, 0, 1);
    step(0, 0, 1);
    chk("single_idle", 128'(busy), 128'(0));

    // Blocked downstream: credits limit acceptance to FIFO_DEPTH.
    n_acc_obs = 0;
    repeat (10) begin rand_vec(); step(1, 0, 0); end
    chk("blocked_accepts", 128'(n_acc_obs), 128'(FIFO_DEPTH));
    chk("blocked_ready", 128'(in_ready), 128'(0));
    repeat (8) step(0, 0, 1);
    chk("blocked_drained", 128'(out_valid), 128'(0));

    // Stream of 20 vectors with downstream always ready.
    n_acc_obs = 0;
    cnt = 0;
    while (n_acc_obs < 20 && cnt < 200) begin rand_vec(); step(1, 0, 1); cnt++; end
    chk("stream_count", 128'(n_acc_obs), 128'(20));
    repeat (12) step(0, 0, 1);
    chk("stream_drained", 128'(out_valid), 128'(0));

    // Flush two cycles after three accepts, with in_valid held high.
    repeat (3) begin rand_vec(); step(1, 0, 0); end
    step(0, 0, 0);
    step(1, 1, 0);
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    cnt = 0;
    repeat (8) begin if (!in_ready) cnt++; step(0, 0, 1); end
    chk("flush_block_len", 128'(cnt), 128'(PIPE_LAT));
    chk("flush_idle", 128'(busy), 128'(0));
    rand_vec();
    step(1, 1, 1);
    rand_vec();
    step(1, 0, 1);
    repeat (12) step(0, 0, 1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      rand_vec();
      rst_n = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
      rst_n = 1'b1;
    end
    repeat (15) step(0, 0, 1);
    chk("final_empty", 128'(out_valid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
